sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 107 ++++++++++
 tb/tb_sync_fifo_param.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read data, occupancy count, threshold flags
// and sticky overflow/underflow error flags.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             write_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             read_i,
  output logic [WIDTH-1:0] data_o,
  output logic             rd_valid_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    w_ptr_q, w_ptr_d;
  logic [AW-1:0]    r_ptr_q, r_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             rd_acc, wr_acc;

  // Status flags come straight off the registered count.
  assign full_o         = (count_q == CW'(DEPTH));
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty_o = (count_q <= CW'(AE_LEVEL));

  assign rd_acc = read_i & ~empty_o & ~flush_i;
  // A full FIFO can still take a write when a read frees a slot the same cycle.
  assign wr_acc = write_i & ~flush_i & (~full_o | rd_acc);

  always_comb begin
    w_ptr_d    = w_ptr_q;
    r_ptr_d    = r_ptr_q;
    count_d    = count_q;
    data_d     = data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (flush_i) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
      data_d  = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_acc) w_ptr_d = w_ptr_q + 1'b1;
      if (rd_acc) begin
        r_ptr_d    = r_ptr_q + 1'b1;
        data_d     = mem_q[r_ptr_q];
        rd_valid_d = 1'b1;
      end
      count_d = count_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
      ovf_d   = ovf_q | (write_i & ~wr_acc);
      unf_d   = unf_q | (read_i & empty_o);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q    <= '0;
      r_ptr_q    <= '0;
      count_q    <= '0;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      w_ptr_q    <= w_ptr_d;
      r_ptr_q    <= r_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage is deliberately left out of reset and flush; only pointers define contents.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[w_ptr_q] <= data_i;
  end

  assign data_o      = data_q;
  assign rd_valid_o  = rd_valid_q;
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst_n;
  logic       flush_i, write_i, read_i;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       rd_valid_o;
  logic [4:0] count_o;
  logic       full_o, empty_o, almost_full_o, almost_empty_o;
  logic       overflow_o, underflow_o;

  int total = 0;
  int bad   = 0;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .write_i       (write_i),
    .data_i        (data_i),
    .read_i        (read_i),
    .data_o        (data_o),
    .rd_valid_o    (rd_valid_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .almost_full_o (almost_full_o),
    .almost_empty_o(almost_empty_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, take the edge, sample 1 ns later, then idle inputs.
  task automatic op(input logic w, input logic [7:0] d, input logic r, input logic f);
    write_i = w; data_i = d; read_i = r; flush_i = f;
    @(posedge clk); #1;
    write_i = 1'b0; read_i = 1'b0; flush_i = 1'b0; data_i = 8'h00;
  endtask

  task automatic fill16(input logic [7:0] base);
    for (int i = 0; i < 16; i++) op(1'b1, base + 8'(i), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    total++; if (count_o !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if ({empty_o, full_o, almost_empty_o, almost_full_o} !== 4'b1010) begin bad++;
      $display("FAIL reset_flags got e/f/ae/af=%b exp=1010", {empty_o, full_o, almost_empty_o, almost_full_o}); end
    total++; if ({rd_valid_o, overflow_o, underflow_o} !== 3'b000) begin bad++;
      $display("FAIL reset_status got=%b exp=000", {rd_valid_o, overflow_o, underflow_o}); end
    total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_o); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      op(1'b1, 8'(i), 1'b0, 1'b0);
      total++; if (count_o !== 5'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count_o, i + 1); end
      total++; if (almost_full_o !== (i + 1 >= 14)) begin bad++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full_o, i + 1 >= 14); end
    end
    total++; if (full_o !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full_o); end
    for (int i = 0; i < 16; i++) begin
      op(1'b0, 8'h00, 1'b1, 1'b0);
      total++; if (data_o !== 8'(i) || rd_valid_o !== 1'b1) begin bad++;
        $display("FAIL drain_data[%0d] got=%h/%b exp=%h/1", i, data_o, rd_valid_o, 8'(i)); end
      total++; if (count_o !== 5'(15 - i)) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count_o, 15 - i); end
    end
    op(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL drain_rdv_drop got=%b exp=0", rd_valid_o); end
    total++; if (data_o !== 8'h0F) begin bad++; $display("FAIL drain_data_hold got=%h exp=0f", data_o); end
    total++; if ({empty_o, overflow_o, underflow_o} !== 3'b100) begin bad++;
      $display("FAIL drain_end got e/ovf/unf=%b exp=100", {empty_o, overflow_o, underflow_o}); end
  endtask

  task automatic test_overflow();
    fill16(8'h20);
    op(1'b1, 8'hAA, 1'b0, 1'b0);
    total++; if (count_o !== 5'd16 || overflow_o !== 1'b1) begin bad++;
      $display("FAIL ovf_set got count=%0d ovf=%b exp count=16 ovf=1", count_o, overflow_o); end
    op(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
    op(1'b1, 8'hBB, 1'b1, 1'b1);
    total++; if ({overflow_o, empty_o, rd_valid_o} !== 3'b010 || count_o !== 5'd0 || data_o !== 8'h00) begin bad++;
      $display("FAIL ovf_flush got ovf/e/rdv=%b count=%0d data=%h exp 010/0/00",
               {overflow_o, empty_o, rd_valid_o}, count_o, data_o); end
  endtask

  task automatic test_full_rw();
    fill16(8'h10);
    op(1'b1, 8'h55, 1'b1, 1'b0);
    total++; if (count_o !== 5'd16 || data_o !== 8'h10 || rd_valid_o !== 1'b1 || overflow_o !== 1'b0) begin bad++;
      $display("FAIL fullrw got count=%0d data=%h rdv=%b ovf=%b exp 16/10/1/0", count_o, data_o, rd_valid_o, overflow_o); end
    for (int i = 1; i <= 16; i++) begin
      op(1'b0, 8'h00, 1'b1, 1'b0);
      total++; if (data_o !== ((i == 16) ? 8'h55 : 8'h10 + 8'(i))) begin bad++;
        $display("FAIL fullrw_drain[%0d] got=%h exp=%h", i, data_o, (i == 16) ? 8'h55 : 8'h10 + 8'(i)); end
    end
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL fullrw_empty got=%b exp=1", empty_o); end
  endtask

  task automatic test_empty_rw();
    op(1'b0, 8'h00, 1'b0, 1'b1);
    op(1'b1, 8'h33, 1'b1, 1'b0);
    total++; if ({underflow_o, rd_valid_o} !== 2'b10 || count_o !== 5'd1) begin bad++;
      $display("FAIL emptyrw got unf/rdv=%b count=%0d exp 10/1", {underflow_o, rd_valid_o}, count_o); end
    op(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (data_o !== 8'h33 || rd_valid_o !== 1'b1 || count_o !== 5'd0) begin bad++;
      $display("FAIL emptyrw_read got data=%h rdv=%b count=%0d exp 33/1/0", data_o, rd_valid_o, count_o); end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic [7:0] nxt;
    nxt = 8'h80;
    op(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin op(1'b1, nxt, 1'b0, 1'b0); q.push_back(nxt); nxt++; end
    total++; if (count_o !== 5'd3 || almost_empty_o !== 1'b0) begin bad++;
      $display("FAIL wrap_prime got count=%0d ae=%b exp 3/0", count_o, almost_empty_o); end
    // 40 read/write pairs push 43 writes through 16 slots: both pointers wrap twice.
    for (int i = 0; i < 40; i++) begin
      op(1'b0, 8'h00, 1'b1, 1'b0);
      exp_d = q.pop_front();
      total++; if (data_o !== exp_d || rd_valid_o !== 1'b1 || count_o !== 5'd2 || almost_empty_o !== 1'b1) begin bad++;
        $display("FAIL wrap_rd[%0d] got data=%h rdv=%b count=%0d ae=%b exp %h/1/2/1",
                 i, data_o, rd_valid_o, count_o, almost_empty_o, exp_d); end
      op(1'b1, nxt, 1'b0, 1'b0); q.push_back(nxt); nxt++;
      total++; if (count_o !== 5'd3 || almost_empty_o !== 1'b0 || rd_valid_o !== 1'b0) begin bad++;
        $display("FAIL wrap_wr[%0d] got count=%0d ae=%b rdv=%b exp 3/0/0", i, count_o, almost_empty_o, rd_valid_o); end
    end
    total++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin bad++;
      $display("FAIL wrap_flags got ovf=%b unf=%b exp 0/0", overflow_o, underflow_o); end
  endtask

  task automatic test_async_reset();
    op(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) op(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (count_o !== 5'd9 || data_o !== 8'h40 || rd_valid_o !== 1'b1) begin bad++;
      $display("FAIL arst_pre got count=%0d data=%h rdv=%b exp 9/40/1", count_o, data_o, rd_valid_o); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (count_o !== 5'd0 || data_o !== 8'h00 || rd_valid_o !== 1'b0) begin bad++;
      $display("FAIL arst_now got count=%0d data=%h rdv=%b exp 0/00/0", count_o, data_o, rd_valid_o); end
    total++; if ({empty_o, full_o, almost_empty_o, almost_full_o} !== 4'b1010) begin bad++;
      $display("FAIL arst_flags got e/f/ae/af=%b exp=1010", {empty_o, full_o, almost_empty_o, almost_full_o}); end
    #2 rst_n = 1'b1;
    op(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (underflow_o !== 1'b1 || rd_valid_o !== 1'b0 || count_o !== 5'd0) begin bad++;
      $display("FAIL arst_underflow got unf=%b rdv=%b count=%0d exp 1/0/0", underflow_o, rd_valid_o, count_o); end
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; write_i = 1'b0; read_i = 1'b0; data_i = 8'h00;
    #12;
    test_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench time limit reached");
  end

endmodule
